// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared widths and FSM state encoding for the register-file write front end
package rf_write_arbiter_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    typedef logic [0:0] arb_state_t;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - requester handshake and register-file write bus with master/slave views
interface rf_write_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rf_enable;
    logic [AW-1:0] rf_wsel;
    logic [DW-1:0] rf_d;
    logic          init_done;
    logic          last_grant;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_enable, rf_wsel, rf_d, init_done, last_grant
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_enable, rf_wsel, rf_d, init_done, last_grant
    );
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// rtl/rf_write_arbiter_rr_arb2.sv - combinational two-way round-robin grant (rr_arb2)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    // Under contention the requester that did not win last time gets the grant.
    assign gnt[0] = valid[0] & (~valid[1] |  last_grant);
    assign gnt[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - write-port owner for the 8x8 register file; RF_WRITE_ARBITER_INIT_EN enables the reset init sweep
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int            DW       = DW_DEF,
    parameter int            AW       = AW_DEF,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    rf_write_arbiter_if.slave bus
);

`ifdef RF_WRITE_ARBITER_INIT_EN
    localparam arb_state_t    ST_RESET = ST_INIT;
    localparam logic [AW-1:0] CNT_LAST = '1;
`else
    localparam arb_state_t    ST_RESET = ST_RUN;
`endif

    arb_state_t    r_state;
    logic          r_rf_enable;
    logic [AW-1:0] r_rf_wsel;
    logic [DW-1:0] r_rf_d;
    logic          r_last_grant;
`ifdef RF_WRITE_ARBITER_INIT_EN
    logic [AW-1:0] r_cnt;
    logic          r_init_done;
`endif

    logic [1:0]    w_gnt;
    logic [1:0]    w_ready;
    logic          w_run;
    logic          w_init_done;

`ifdef RF_WRITE_ARBITER_INIT_EN
    assign w_run       = (r_state == ST_RUN);
    assign w_init_done = r_init_done;
`else
    // Without a sweep the arbiter is live the moment reset lets go.
    assign w_run       = clr_n & (r_state == ST_RUN);
    assign w_init_done = clr_n;
    logic  w_unused_init_val;
    assign w_unused_init_val = ^INIT_VAL;
`endif

    rr_arb2 u_rr_arb2 (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (r_last_grant),
        .gnt        (w_gnt)
    );

    assign w_ready = w_gnt & {2{w_run}};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= ST_RESET;
            r_rf_enable  <= 1'b0;
            r_rf_wsel    <= '0;
            r_rf_d       <= '0;
            r_last_grant <= 1'b1;
`ifdef RF_WRITE_ARBITER_INIT_EN
            r_cnt        <= '0;
            r_init_done  <= 1'b0;
`endif
        end else begin
`ifdef RF_WRITE_ARBITER_INIT_EN
            if (r_state == ST_INIT) begin
                r_rf_enable <= 1'b1;
                r_rf_wsel   <= r_cnt;
                r_rf_d      <= INIT_VAL;
                r_cnt       <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                end
            end else
`endif
            begin
                if (w_ready[0]) begin
                    r_rf_enable  <= 1'b1;
                    r_rf_wsel    <= bus.req0_addr;
                    r_rf_d       <= bus.req0_data;
                    r_last_grant <= 1'b0;
                end else if (w_ready[1]) begin
                    r_rf_enable  <= 1'b1;
                    r_rf_wsel    <= bus.req1_addr;
                    r_rf_d       <= bus.req1_data;
                    r_last_grant <= 1'b1;
                end else begin
                    // Select and data hold so the file sees a stable bus between writes.
                    r_rf_enable  <= 1'b0;
                end
            end
        end
    end

    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];
    assign bus.rf_enable  = r_rf_enable;
    assign bus.rf_wsel    = r_rf_wsel;
    assign bus.rf_d       = r_rf_d;
    assign bus.init_done  = w_init_done;
    assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic clk;
    logic clr_n;
    int   total;
    int   bad;

    rf_write_arbiter_if #(.DW(8), .AW(3)) bus ();

    rf_write_arbiter #(.DW(8), .AW(3), .INIT_VAL(8'h00)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_reqs();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 3'd0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 3'd0;
        bus.req1_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic skip_sweep();
`ifdef RF_WRITE_ARBITER_INIT_EN
        repeat (8) step();
`else
        #1;
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_n = 1'b0;
        idle_reqs();
`ifdef RF_WRITE_ARBITER_INIT_EN
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd3;
        bus.req0_data  = 8'hAA;
`else
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd7;
        bus.req1_data  = 8'hBA;
`endif
        #12;
        chk("rst_en",        bus.rf_enable,  1'b0);
        chk("rst_wsel",      bus.rf_wsel,    3'd0);
        chk("rst_d",         bus.rf_d,       8'h00);
        chk("rst_init_done", bus.init_done,  1'b0);
        chk("rst_last",      bus.last_grant, 1'b1);
        chk("rst_rdy0",      bus.req0_ready, 1'b0);
        chk("rst_rdy1",      bus.req1_ready, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;

`ifdef RF_WRITE_ARBITER_INIT_EN
        for (int i = 0; i < 8; i++) begin
            step();
            chk("sweep_en",   bus.rf_enable,  1'b1);
            chk("sweep_wsel", bus.rf_wsel,    i[2:0]);
            chk("sweep_d",    bus.rf_d,       8'h00);
            chk("sweep_done", bus.init_done,  (i == 7));
            chk("sweep_rdy0", bus.req0_ready, (i == 7));
        end
        step();
        chk("single_en",   bus.rf_enable,  1'b1);
        chk("single_wsel", bus.rf_wsel,    3'd3);
        chk("single_d",    bus.rf_d,       8'hAA);
        chk("single_last", bus.last_grant, 1'b0);
        idle_reqs();
        step();
        chk("single_idle", bus.rf_enable, 1'b0);
`else
        #1;
        chk("noinit_done", bus.init_done,  1'b1);
        chk("noinit_rdy1", bus.req1_ready, 1'b1);
        step();
        chk("noinit_en",   bus.rf_enable,  1'b1);
        chk("noinit_wsel", bus.rf_wsel,    3'd7);
        chk("noinit_d",    bus.rf_d,       8'hBA);
        chk("noinit_last", bus.last_grant, 1'b1);
        idle_reqs();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd3;
        bus.req0_data  = 8'hAA;
        #1;
        chk("single_rdy0", bus.req0_ready, 1'b1);
        step();
        chk("single_en",   bus.rf_enable,  1'b1);
        chk("single_wsel", bus.rf_wsel,    3'd3);
        chk("single_d",    bus.rf_d,       8'hAA);
        chk("single_last", bus.last_grant, 1'b0);
        idle_reqs();
        step();
        chk("single_idle", bus.rf_enable, 1'b0);
`endif

        // Contention from a fresh reset: grants alternate 0,1,0,1.
        do_reset();
        skip_sweep();
        chk("cont_last0", bus.last_grant, 1'b1);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd1;
        bus.req0_data  = 8'h11;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd2;
        bus.req1_data  = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_rdy0", bus.req0_ready, (k % 2 == 0));
            chk("cont_rdy1", bus.req1_ready, (k % 2 == 1));
            step();
            chk("cont_en",   bus.rf_enable,  1'b1);
            chk("cont_d",    bus.rf_d,       (k % 2 == 0) ? 8'h11 : 8'h22);
            chk("cont_wsel", bus.rf_wsel,    (k % 2 == 0) ? 3'd1 : 3'd2);
            chk("cont_last", bus.last_grant, (k % 2 == 1));
        end
        idle_reqs();
        step();
        chk("hold_en",   bus.rf_enable, 1'b0);
        chk("hold_wsel", bus.rf_wsel,   3'd2);
        chk("hold_d",    bus.rf_d,      8'h22);

        // Same address: two pulses, second grantee's data lands last.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd5;
        bus.req0_data  = 8'h5A;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 3'd5;
        bus.req1_data  = 8'hA5;
        #1;
        chk("same_rdy0", bus.req0_ready, 1'b1);
        chk("same_rdy1", bus.req1_ready, 1'b0);
        step();
        chk("same_en1", bus.rf_enable, 1'b1);
        chk("same_w1",  bus.rf_wsel,   3'd5);
        chk("same_d1",  bus.rf_d,      8'h5A);
        bus.req0_valid = 1'b0;
        #1;
        chk("same_rdy1b", bus.req1_ready, 1'b1);
        step();
        chk("same_en2", bus.rf_enable, 1'b1);
        chk("same_d2",  bus.rf_d,      8'hA5);
        idle_reqs();
        step();
        chk("same_idle", bus.rf_enable, 1'b0);
        chk("same_fin",  bus.rf_d,      8'hA5);

`ifdef RF_WRITE_ARBITER_INIT_EN
        do_reset();
        repeat (5) step();
        chk("mid_wsel4", bus.rf_wsel, 3'd4);
        #1;
        clr_n = 1'b0;
        #1;
        chk("mid_en",   bus.rf_enable, 1'b0);
        chk("mid_wsel", bus.rf_wsel,   3'd0);
        chk("mid_done", bus.init_done, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        step();
        chk("restart_en",   bus.rf_enable, 1'b1);
        chk("restart_wsel", bus.rf_wsel,   3'd0);
`else
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 3'd6;
        bus.req0_data  = 8'h66;
        step();
        chk("mid_pre_en", bus.rf_enable, 1'b1);
        #1;
        clr_n = 1'b0;
        #1;
        chk("mid_en",   bus.rf_enable,  1'b0);
        chk("mid_d",    bus.rf_d,       8'h00);
        chk("mid_last", bus.last_grant, 1'b1);
        chk("mid_rdy0", bus.req0_ready, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk("restart_rdy0", bus.req0_ready, 1'b1);
        step();
        chk("restart_en",   bus.rf_enable, 1'b1);
        chk("restart_d",    bus.rf_d,      8'h66);
        idle_reqs();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
